chip8_video_compositor: RTL and testbench
=========================================

CHIP8_VIDEO_COMPOSITOR -- requirements
Module: chip8_video_compositor

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, meaning number of CHIP-8 framebuffers in VRAM (legal 1..4).
REQ-002 SHALL provide parameter SCALE_LOG2, default 4, meaning log2 pixel magnification in single mode (legal 2..5).
REQ-003 SHALL provide parameter VRAM_LATENCY, default 2, meaning cycles from hdmi_addr_out to valid hdmi_data_in (legal 1..4).
REQ-004 SHALL provide parameter CH_STRIDE_LOG2, default 8, meaning log2 of bytes between channel framebuffer bases.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk_in  input  1  system/pixel clock, all logic on rising edge.
REQ-007 rst_in  input  1  synchronous active-low reset.
REQ-008 hcount_in  input  11  HDMI column, [0,1280).
REQ-009 vcount_in  input  10  HDMI row, [0,720).
REQ-010 mode_in  input  1  0 = single channel full view, 1 = 2x2 grid.
REQ-011 sel_in  input  2  channel shown in single mode.
REQ-012 hdmi_data_in  input  8  VRAM byte, VRAM_LATENCY cycles after address.
REQ-013 hdmi_addr_out  output  16  registered VRAM byte address.
REQ-014 hdmi_pixel_out  output  1  pixel value, aligned per REQ-022.
REQ-015 in_view_out  output  1  pixel lies inside an enabled viewport.
REQ-016 ch_out  output  2  channel owning the pixel (0 outside viewport).
REQ-017 border_out  output  1  border pixel flag (tied 0 when border feature absent).

Function
REQ-018 mode_in/sel_in SHALL be latched only in the cycle hcount_in==0 && vcount_in==0; latched values govern the whole frame (no mid-frame tearing).
REQ-019 Single mode: scale S=SCALE_LOG2, one viewport origin (0,0), size (64<<S)x(32<<S), channel = latched sel; sel >= NUM_CH SHALL give in_view 0.
REQ-020 Grid mode: scale S=SCALE_LOG2-1; channel c at origin ((c%2)*(64<<S), (c/2)*(32<<S)); channels c >= NUM_CH out of view.
REQ-021 Inside a viewport: lx=(hcount-ox)>>S (6b), ly=(vcount-oy)>>S (5b); address = (c<<CH_STRIDE_LOG2) + ly*8 + lx[5:3], zero-extended to 16 bits; outside: address 0.
REQ-022 Address SHALL be registered (1 cycle); pixel/in_view/ch/border outputs SHALL appear exactly L = 1+VRAM_LATENCY cycles after the hcount/vcount sample, via a shift pipeline carrying bit offset lx[2:0], in_view, channel, border.
REQ-023 Pixel = bit lx[2:0] of hdmi_data_in (bit 0 = leftmost); forced 0 when in_view is 0.
REQ-024 Pipeline SHALL advance every cycle unconditionally; counts outside the active area (hcount>=1280 or vcount>=720) are out of view.
REQ-025 Viewport bounds SHALL be half-open: x in [ox, ox+(64<<S)), y in [oy, oy+(32<<S)); last column/row in view, next is not.

Reset
REQ-026 While rst_in==0: hdmi_addr_out=0, hdmi_pixel_out=0, in_view_out=0, ch_out=0, border_out=0, all pipeline stages cleared, latched mode=0, latched sel=0.
REQ-027 Reset mid-frame SHALL take effect next edge; after release outputs stay 0 until L cycles of fresh samples propagate; mode/sel remain 0 until the next frame start.

Configuration
REQ-028 Macro CHIP8_VID_BORDER_EN: when defined, border_out=1 (and in_view_out=1, pixel 0) for the 1-pixel ring immediately outside each enabled viewport, aligned per REQ-022; where rings overlap a viewport, the viewport wins.
REQ-029 Without CHIP8_VID_BORDER_EN: border_out constant 0, no border logic synthesised.

Verification
REQ-030 Single mode, sel=0, VRAM_LATENCY=2, byte @0x0000=0x01: sample (0,0) -> addr 0x0000 after 1 cycle, pixel 1, in_view 1, ch 0 after 3 cycles; sample (16,0) -> pixel 0.
REQ-031 Single mode, sel=2: sample (1023,511) -> addr 0x02FF; sample (1024,0) -> in_view 0, pixel 0, addr 0.
REQ-032 Grid mode NUM_CH=4: sample (512,256) -> ch 3, addr 0x0300; sample (511,255) -> ch 0, addr 0x00FF; NUM_CH=3 sample (512,256) -> in_view 0.
REQ-033 Toggle mode_in 0->1 at (100,100) -> behaviour unchanged until next (0,0) sample, then grid mapping.
REQ-034 Assert rst_in low for 1 cycle mid-line -> all outputs 0 next edge, first valid pixel 3 cycles after release.
REQ-035 With CHIP8_VID_BORDER_EN, single mode: sample (1024,10) -> border 1, in_view 1, pixel 0; sample (1025,10) -> border 0.

Source files
------------

// File: rtl/chip8_video_compositor.sv
// chip8_video_compositor: maps HDMI raster counts onto one (single mode) or up
// to four (2x2 grid mode) CHIP-8 64x32 framebuffers held in VRAM. Issues a
// registered VRAM byte address and realigns pixel metadata with the returned
// byte through a fixed-depth shift pipeline.
// Optional feature: define CHIP8_VID_BORDER_EN to draw a 1-pixel ring around
// every enabled viewport.
module chip8_video_compositor #(
  parameter int NUM_CH         = 4,
  parameter int SCALE_LOG2     = 4,
  parameter int VRAM_LATENCY   = 2,
  parameter int CH_STRIDE_LOG2 = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        mode_in,
  input  logic [1:0]  sel_in,
  input  logic [7:0]  hdmi_data_in,
  output logic [15:0] hdmi_addr_out,
  output logic        hdmi_pixel_out,
  output logic        in_view_out,
  output logic [1:0]  ch_out,
  output logic        border_out
);

  localparam int SS = SCALE_LOG2;      // single-mode scale
  localparam int SG = SCALE_LOG2 - 1;  // grid-mode scale
  localparam logic [12:0] W_S = 13'(64 << SS);
  localparam logic [12:0] H_S = 13'(32 << SS);
  localparam logic [12:0] W_G = 13'(64 << SG);
  localparam logic [12:0] H_G = 13'(32 << SG);

  // metadata that travels alongside the VRAM read
  typedef struct packed {
    logic [2:0] off;
    logic       view;
    logic [1:0] ch;
    logic       border;
  } tap_t;

  logic        mode_q, mode_eff;
  logic [1:0]  sel_q, sel_eff;
  logic        frame_start, active_area;
  logic [12:0] hc, vc, w, h;
  logic        hit, border_c;
  logic [1:0]  hit_ch;
  logic [12:0] dx, dy;
  logic [5:0]  lx;
  logic [4:0]  ly;
  logic [15:0] addr_c;
  tap_t        cur;
  tap_t        pipe [VRAM_LATENCY+1];

  assign frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  // the frame-start sample already uses the new mode/sel, so the whole frame is consistent
  assign mode_eff    = frame_start ? mode_in : mode_q;
  assign sel_eff     = frame_start ? sel_in  : sel_q;
  assign active_area = (hcount_in < 11'd1280) && (vcount_in < 10'd720);
  assign hc          = {2'b00, hcount_in};
  assign vc          = {3'b000, vcount_in};
  assign w           = mode_eff ? W_G : W_S;
  assign h           = mode_eff ? H_G : H_S;

  // mode/sel are captured only at frame start to avoid mid-frame tearing
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      mode_q <= 1'b0;
      sel_q  <= 2'b00;
    end else if (frame_start) begin
      mode_q <= mode_in;
      sel_q  <= sel_in;
    end
  end

  // viewport hit test (lowest channel wins) and optional ring detection
  always_comb begin
    logic        en;
    logic [12:0] ox, oy;
    logic        ring;
    hit    = 1'b0;
    hit_ch = 2'b00;
    dx     = '0;
    dy     = '0;
    en     = 1'b0;
    ox     = '0;
    oy     = '0;
    ring   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      en = (c < NUM_CH) && (mode_eff || (sel_eff == 2'(c)));
      ox = (mode_eff && (c % 2 == 1)) ? w : 13'd0;
      oy = (mode_eff && (c >= 2))     ? h : 13'd0;
      if (en && active_area && !hit &&
          hc >= ox && hc < ox + w && vc >= oy && vc < oy + h) begin
        hit    = 1'b1;
        hit_ch = 2'(c);
        dx     = hc - ox;
        dy     = vc - oy;
      end
      if (en && hc + 13'd1 >= ox && hc <= ox + w &&
          vc + 13'd1 >= oy && vc <= oy + h)
        ring = 1'b1;
    end
`ifdef CHIP8_VID_BORDER_EN
    border_c = ring && !hit && active_area;
`else
    border_c = 1'b0;
`endif
  end

  assign lx     = mode_eff ? 6'(dx >> SG) : 6'(dx >> SS);
  assign ly     = mode_eff ? 5'(dy >> SG) : 5'(dy >> SS);
  assign addr_c = hit ? ((16'(hit_ch) << CH_STRIDE_LOG2) + {8'd0, ly, 3'b000} + {13'd0, lx[5:3]})
                      : 16'd0;

  assign cur.off    = lx[2:0];
  assign cur.view   = hit || border_c;
  assign cur.ch     = hit_ch;
  assign cur.border = border_c;

  // address register plus metadata delay line matching VRAM latency
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      hdmi_addr_out <= 16'd0;
      for (int i = 0; i <= VRAM_LATENCY; i++) pipe[i] <= '0;
    end else begin
      hdmi_addr_out <= addr_c;
      pipe[0]       <= cur;
      for (int i = 1; i <= VRAM_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end

  // last stage lines up with the returned VRAM byte; border pixels are dark
  assign in_view_out    = pipe[VRAM_LATENCY].view;
  assign ch_out         = pipe[VRAM_LATENCY].ch;
  assign hdmi_pixel_out = pipe[VRAM_LATENCY].view && !pipe[VRAM_LATENCY].border &&
                          hdmi_data_in[pipe[VRAM_LATENCY].off];
`ifdef CHIP8_VID_BORDER_EN
  assign border_out     = pipe[VRAM_LATENCY].border;
`else
  assign border_out     = 1'b0;
`endif

endmodule

// File: tb/tb_chip8_video_compositor.sv
// Directed-vector bench for chip8_video_compositor: a table of raster samples
// with hand-computed results, plus sequences for frame latching and reset.
module tb_chip8_video_compositor;
  localparam int LAT = 2;
  localparam int L   = 1 + LAT;
`ifdef CHIP8_VID_BORDER_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  data;
  logic [15:0] addr, addr3;
  logic        pix, view, bord, pix3, view3, bord3;
  logic [1:0]  ch, ch3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chip8_video_compositor #(.NUM_CH(4), .SCALE_LOG2(4), .VRAM_LATENCY(LAT), .CH_STRIDE_LOG2(8)) dut (
    .clk_in(clk), .rst_in(rst_n), .hcount_in(hc), .vcount_in(vc), .mode_in(mode),
    .sel_in(sel), .hdmi_data_in(data), .hdmi_addr_out(addr), .hdmi_pixel_out(pix),
    .in_view_out(view), .ch_out(ch), .border_out(bord));

  chip8_video_compositor #(.NUM_CH(3), .SCALE_LOG2(4), .VRAM_LATENCY(LAT), .CH_STRIDE_LOG2(8)) dut3 (
    .clk_in(clk), .rst_in(rst_n), .hcount_in(hc), .vcount_in(vc), .mode_in(mode),
    .sel_in(sel), .hdmi_data_in(data), .hdmi_addr_out(addr3), .hdmi_pixel_out(pix3),
    .in_view_out(view3), .ch_out(ch3), .border_out(bord3));

  // VRAM model: sparse contents, LAT-cycle read latency
  logic [7:0] mem [0:65535];
  logic [7:0] vq0, vq1;
  always @(posedge clk) begin
    vq0 <= mem[addr];
    vq1 <= vq0;
  end
  assign data = vq1;

  typedef struct {
    int hc; int vc; bit mode; int sel;
    int addr; bit view; int ch; bit pix; bit border; bit view3;
  } vec_t;
  vec_t vt [16];
  int nv;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int h, input int v, input bit m, input int s);
    @(negedge clk);
    hc = 11'(h); vc = 10'(v); mode = m; sel = 2'(s);
  endtask

  task automatic run_vec(input int i);
    drive(0, 0, vt[i].mode, vt[i].sel);           // frame start latches mode/sel
    drive(vt[i].hc, vt[i].vc, vt[i].mode, vt[i].sel);
    @(negedge clk);
    chk($sformatf("v%0d addr", i), int'(addr), vt[i].addr);
    repeat (L - 1) @(negedge clk);
    chk($sformatf("v%0d view", i), int'(view), int'(vt[i].view));
    chk($sformatf("v%0d ch", i), int'(ch), vt[i].ch);
    chk($sformatf("v%0d pix", i), int'(pix), int'(vt[i].pix));
    chk($sformatf("v%0d border", i), int'(bord), int'(vt[i].border));
    chk($sformatf("v%0d view3", i), int'(view3), int'(vt[i].view3));
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[16'h0000] = 8'h01;
    mem[16'h02FF] = 8'h80;
    mem[16'h0300] = 8'h01;
    mem[16'h00FF] = 8'h80;

    //          hc    vc  mode sel addr     view ch pix border view3
    vt[0]  = '{0,    0,   0, 0, 'h0000, 1,   0, 1,  0,   1};
    vt[1]  = '{16,   0,   0, 0, 'h0000, 1,   0, 0,  0,   1};
    vt[2]  = '{1023, 511, 0, 2, 'h02FF, 1,   2, 1,  0,   1};
    vt[3]  = '{1024, 0,   0, 2, 'h0000, BEN, 0, 0,  BEN, BEN};
    vt[4]  = '{512,  256, 1, 0, 'h0300, 1,   3, 1,  0,   BEN};
    vt[5]  = '{511,  255, 1, 0, 'h00FF, 1,   0, 1,  0,   1};
    vt[6]  = '{1024, 100, 1, 0, 'h0000, BEN, 0, 0,  BEN, BEN};
    vt[7]  = '{5,    5,   0, 3, 'h0300, 1,   3, 1,  0,   0};
    vt[8]  = '{1300, 0,   0, 0, 'h0000, 0,   0, 0,  0,   0};
    vt[9]  = '{100,  600, 0, 1, 'h0000, 0,   0, 0,  0,   0};
    vt[10] = '{200,  100, 0, 1, 'h0131, 1,   1, 0,  0,   1};
    vt[11] = '{1024, 10,  0, 0, 'h0000, BEN, 0, 0,  BEN, BEN};
    vt[12] = '{1025, 10,  0, 0, 'h0000, 0,   0, 0,  0,   0};
    nv = 13;

    rst_n = 1'b0; hc = '0; vc = '0; mode = 1'b0; sel = 2'd0;
    repeat (4) @(negedge clk);
    chk("rst addr", int'(addr), 0);
    chk("rst view", int'(view), 0);
    chk("rst pix", int'(pix), 0);
    chk("rst ch", int'(ch), 0);
    chk("rst border", int'(bord), 0);
    rst_n = 1'b1;

    for (int i = 0; i < nv; i++) run_vec(i);

    // mode change mid-frame is ignored until the next frame start
    drive(0, 0, 0, 0);
    drive(100, 100, 1, 0);
    @(negedge clk);
    chk("latch hold addr", int'(addr), 'h0030);
    drive(0, 0, 1, 0);
    drive(100, 100, 0, 0);
    @(negedge clk);
    chk("latch grid addr", int'(addr), 'h0061);

    // one-cycle reset mid-line
    drive(0, 0, 0, 1);
    drive(200, 100, 0, 1);
    repeat (L) @(negedge clk);
    chk("pre-rst view", int'(view), 1);
    chk("pre-rst ch", int'(ch), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst addr", int'(addr), 0);
    chk("midrst view", int'(view), 0);
    chk("midrst ch", int'(ch), 0);
    chk("midrst pix", int'(pix), 0);
    rst_n = 1'b1;                                  // sel reverts to 0 until next frame
    @(negedge clk);
    chk("post-rst addr", int'(addr), 'h0031);
    chk("post-rst view c1", int'(view), 0);
    @(negedge clk);
    chk("post-rst view c2", int'(view), 0);
    @(negedge clk);
    chk("post-rst view c3", int'(view), 1);
    chk("post-rst ch", int'(ch), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
